// File: rtl/uart_tx_arbiter.sv
// Shared 8N1 UART transmitter fed by two byte ports through a req/gnt arbiter.
// Bit timing comes from a per-frame counter on the system clock, so no divided clock is needed.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prio,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt1,
  output logic       txd,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        txd_q, txd_d;

  logic        bit_done;
  logic        any_req;
  logic        winner;

  assign bit_done = (cnt_q == LAST_CNT);
  assign any_req  = req0 | req1;

  // A lone requester always wins; ties go to port 1 under prio, else alternate.
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      winner = prio ? 1'b1 : ~last_grant_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (any_req) begin
          state_d      = START;
          shift_d      = winner ? data1 : data0;
          owner_d      = winner;
          last_grant_d = winner;
          gnt0_d       = ~winner;
          gnt1_d       = winner;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line level is registered from the next state so txd changes on the same edge as state.
  always_comb begin
    txd_d = 1'b1;
    if (state_d == START) begin
      txd_d = 1'b0;
    end else if (state_d == DATA) begin
      txd_d = shift_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      txd_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      txd_q        <= txd_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign txd   = txd_q;
  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLKS_PER_BIT=4: reset, framing, arbitration modes,
// mid-frame requests and mid-frame reset.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst;
  logic       prio;
  logic       req0;
  logic [7:0] data0;
  logic       gnt0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt1;
  logic       txd;
  logic       busy;
  logic       owner;

  int errors;
  int checks;

  uart_tx_arbiter #(.CLKS_PER_BIT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .prio  (prio),
    .req0  (req0),
    .data0 (data0),
    .gnt0  (gnt0),
    .req1  (req1),
    .data1 (data1),
    .gnt1  (gnt1),
    .txd   (txd),
    .busy  (busy),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Ticks until a grant pulse is seen; waited is the number of edges taken.
  task automatic wait_grant(output bit ok, output logic port, output int waited);
    ok     = 1'b0;
    port   = 1'b0;
    waited = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      waited++;
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        ok   = 1'b1;
        port = gnt1;
      end
    end
  endtask

  // Starts at the sample just after the grant edge and records 40 cycles of line activity.
  task automatic capture_frame(output logic [9:0] bits, output bit stable, output int busy_n,
                               output int g0_n, output int g1_n);
    bits   = '0;
    stable = 1'b1;
    busy_n = 0;
    g0_n   = 0;
    g1_n   = 0;
    for (int t = 0; t < 40; t++) begin
      if (t != 0) tick();
      if (t % 4 == 0) bits[t/4] = txd;
      else if (txd !== bits[t/4]) stable = 1'b0;
      if (busy === 1'b1) busy_n++;
      if (gnt0 === 1'b1) g0_n++;
      if (gnt1 === 1'b1) g1_n++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    prio  = 1'b0;
    req0  = 1'b1;
    data0 = 8'h12;
    req1  = 1'b0;
    data1 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({txd, busy, gnt0, gnt1, owner} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: txd/busy/gnt0/gnt1/owner=%b expected 10000", i,
                 {txd, busy, gnt0, gnt1, owner});
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({gnt0, gnt1, busy, txd, owner} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_release_grant: gnt0/gnt1/busy/txd/owner=%b expected 10100",
               {gnt0, gnt1, busy, txd, owner});
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL gnt0_one_cycle: gnt0=%b expected 0", gnt0);
    end
    for (int t = 2; t <= 40; t++) begin
      tick();
      if (t == 39) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_last_cycle: busy=%b expected 1", busy);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL frame_end_idle: busy=%b txd=%b expected 0 1", busy, txd);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_byte();
    logic [9:0] bits;
    bit         stable;
    int         busy_n, g0_n, g1_n;
    data0 = 8'h55;
    req0  = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || owner !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: gnt0=%b owner=%b expected 1 0", gnt0, owner);
    end
    req0 = 1'b0;
    capture_frame(bits, stable, busy_n, g0_n, g1_n);
    checks++;
    if (bits !== 10'b1010101010 || !stable) begin
      errors++;
      $display("FAIL single_bits: bits=%b stable=%0d expected 1010101010 1", bits, stable);
    end
    checks++;
    if (busy_n != 40 || g0_n != 1 || g1_n != 0) begin
      errors++;
      $display("FAIL single_busy_gnt: busy=%0d g0=%0d g1=%0d expected 40 1 0",
               busy_n, g0_n, g1_n);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: busy=%b txd=%b expected 0 1", busy, txd);
    end
    $display("test_single_byte done");
  endtask

  task automatic test_round_robin();
    logic [9:0] bits;
    bit         stable, ok;
    logic       port;
    int         busy_n, g0_n, g1_n, waited;
    logic [7:0] exp_byte;
    do_reset();
    prio  = 1'b0;
    data0 = 8'hA5;
    data1 = 8'h3C;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(ok, port, waited);
      checks++;
      if (!ok || port !== 1'(i % 2) || owner !== 1'(i % 2)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: ok=%0d port=%b owner=%b expected port %0d", i, ok,
                 port, owner, i % 2);
      end
      if (i > 0) begin
        checks++;
        if (waited != 2) begin
          errors++;
          $display("FAIL rr_period[%0d]: edges=%0d expected 2 (41-cycle period)", i, waited);
        end
      end
      capture_frame(bits, stable, busy_n, g0_n, g1_n);
      exp_byte = (i % 2 == 1) ? 8'h3C : 8'hA5;
      checks++;
      if (bits !== {1'b1, exp_byte, 1'b0} || !stable || (g0_n + g1_n) != 1) begin
        errors++;
        $display("FAIL rr_frame[%0d]: bits=%b stable=%0d gnts=%0d expected %b 1 1", i, bits,
                 stable, g0_n + g1_n, {1'b1, exp_byte, 1'b0});
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    $display("test_round_robin done");
  endtask

  task automatic test_fixed_priority();
    logic [9:0] bits;
    bit         stable, ok;
    logic       port;
    int         busy_n, g0_n, g1_n, waited;
    prio  = 1'b1;
    data0 = 8'h11;
    data1 = 8'hC3;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_grant(ok, port, waited);
      checks++;
      if (!ok || port !== 1'b1 || waited != 2) begin
        errors++;
        $display("FAIL prio_grant[%0d]: ok=%0d port=%b edges=%0d expected port 1 edges 2", i,
                 ok, port, waited);
      end
      if (i == 2) req1 = 1'b0;
      capture_frame(bits, stable, busy_n, g0_n, g1_n);
      checks++;
      if (bits[8:1] !== 8'hC3 || g0_n != 0) begin
        errors++;
        $display("FAIL prio_frame[%0d]: byte=%h g0=%0d expected c3 0", i, bits[8:1], g0_n);
      end
    end
    wait_grant(ok, port, waited);
    checks++;
    if (!ok || port !== 1'b0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL prio_fallback: ok=%0d port=%b owner=%b expected port 0", ok, port, owner);
    end
    req0 = 1'b0;
    capture_frame(bits, stable, busy_n, g0_n, g1_n);
    checks++;
    if (bits[8:1] !== 8'h11) begin
      errors++;
      $display("FAIL prio_fallback_byte: byte=%h expected 11", bits[8:1]);
    end
    prio = 1'b0;
    $display("test_fixed_priority done");
  endtask

  task automatic test_mid_frame_request();
    logic [9:0] bits;
    bit         stable, ok;
    logic       port;
    int         busy_n, g0_n, g1_n, waited, early;
    data0 = 8'h0F;
    req0  = 1'b1;
    wait_grant(ok, port, waited);
    checks++;
    if (!ok || port !== 1'b0) begin
      errors++;
      $display("FAIL mid_first_grant: ok=%0d port=%b expected port 0", ok, port);
    end
    req0  = 1'b0;
    early = 0;
    for (int t = 1; t <= 39; t++) begin
      tick();
      if (t == 12) begin
        req1  = 1'b1;
        data1 = 8'h81;
      end
      if (gnt1 === 1'b1) early++;
    end
    checks++;
    if (early != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_no_early_gnt: gnt1 pulses=%0d busy=%b expected 0 1", early, busy);
    end
    tick();
    checks++;
    if (gnt1 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle_cycle: gnt1=%b busy=%b expected 0 0", gnt1, busy);
    end
    tick();
    checks++;
    if (gnt1 !== 1'b1 || owner !== 1'b1 || txd !== 1'b0) begin
      errors++;
      $display("FAIL mid_late_grant: gnt1=%b owner=%b txd=%b expected 1 1 0", gnt1, owner, txd);
    end
    req1 = 1'b0;
    capture_frame(bits, stable, busy_n, g0_n, g1_n);
    checks++;
    if (bits !== {1'b1, 8'h81, 1'b0} || !stable || busy_n != 40) begin
      errors++;
      $display("FAIL mid_frame_bits: bits=%b stable=%0d busy=%0d expected %b 1 40", bits,
               stable, busy_n, {1'b1, 8'h81, 1'b0});
    end
    $display("test_mid_frame_request done");
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    bit         stable, ok;
    logic       port;
    int         busy_n, g0_n, g1_n, waited;
    prio  = 1'b0;
    data0 = 8'h00;
    req0  = 1'b1;
    wait_grant(ok, port, waited);
    req0 = 1'b0;
    for (int t = 1; t <= 17; t++) tick();
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_bit3: txd=%b busy=%b expected 0 1", txd, busy);
    end
    rst   = 1'b0;
    data0 = 8'hA5;
    data1 = 8'h5A;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({txd, busy, gnt0, gnt1} !== 4'b1000) begin
        errors++;
        $display("FAIL rstmid_abort[%0d]: txd/busy/gnt0/gnt1=%b expected 1000", i,
                 {txd, busy, gnt0, gnt1});
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_first_tie: gnt0=%b gnt1=%b owner=%b expected 1 0 0", gnt0, gnt1,
               owner);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    capture_frame(bits, stable, busy_n, g0_n, g1_n);
    checks++;
    if (bits[8:1] !== 8'hA5 || !stable) begin
      errors++;
      $display("FAIL rstmid_next_byte: byte=%h stable=%0d expected a5 1", bits[8:1], stable);
    end
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    prio   = 1'b0;
    req0   = 1'b0;
    req1   = 1'b0;
    data0  = 8'h00;
    data1  = 8'h00;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_fixed_priority();
    test_mid_frame_request();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shared UART 8N1 transmitter with a two-port byte arbiter. It replaces the per-mode transmitters and the output-select mux at the top of the UART design. The echo path (port 0) and the message path (port 1) each hand bytes over through a req/gnt handshake. The block owns the bit-period timing, so no divided clock is needed: everything runs on the 100 MHz system clock.

## Interface
Parameters:
- CLKS_PER_BIT, default 10416: system clocks per serial bit (100 MHz / 9600). Legal range is 2..65535.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- prio  in  1  arbitration mode: 0 = round-robin, 1 = fixed priority to port 1. Sampled only at arbitration.
- req0  in  1  port 0 (echo) byte request.
- data0  in  8  port 0 byte; must be stable while req0 is high and gnt0 is low.
- gnt0  out  1  one-cycle pulse: the port 0 byte was latched.
- req1  in  1  port 1 (message) byte request.
- data1  in  8  port 1 byte; same stability rule as data0.
- gnt1  out  1  one-cycle pulse: the port 1 byte was latched.
- txd  out  1  serial line; idle high.
- busy  out  1  high whenever state ≠ IDLE.
- owner  out  1  port that owns the current or most recent frame.

## Operation
- States: IDLE, START, DATA, STOP.
- Registers:
  - bit counter: 16 bits, counts 0..CLKS_PER_BIT-1.
  - bit index: 3 bits.
  - shift register: 8 bits.
  - last_grant: 1 bit.
- IDLE:
  - txd = 1.
  - On an edge where at least one req is sampled high, the block:
    - selects a winner;
    - latches that port's data into the shift register;
    - sets owner and last_grant to the winner;
    - registers gnt for the winner;
    - moves to START with txd = 0;
    - clears the bit counter.
- Winner selection:
  - Only one req high: that port wins.
  - Both high, prio=1: port 1 wins.
  - Both high, prio=0: the port ≠ last_grant wins.
- START: txd = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - txd = shift[0] (LSB first) for CLKS_PER_BIT cycles per bit.
  - Then shift right and increment the bit index.
  - After bit 7, go to STOP.
- STOP: txd = 1 for CLKS_PER_BIT cycles, then IDLE.
- Arbitration never happens outside IDLE. Requests arriving mid-frame wait, with no loss and no gnt.
- The bit counter runs only inside a frame and restarts at every bit boundary. Bit width is exact, with no drift from a free-running divider.
- Reset values (rst=0 at an edge):
  - outputs: txd=1, busy=0, gnt0=gnt1=0, owner=0;
  - internal: last_grant=1, so port 0 wins the first tie; state=IDLE; counters=0.
- Reset mid-frame:
  - The frame aborts at that edge and txd goes to 1.
  - Any pending request is not granted during reset.
  - No gnt is issued for the aborted byte beyond the one already issued.

## Timing
- Grant latency:
  - req sampled high at IDLE edge E → gnt high during the cycle after E, for exactly one cycle.
  - txd falls at the same edge E.
- Frame length:
  - start + 8 data + stop = 10·CLKS_PER_BIT cycles.
  - Then at least one IDLE cycle.
  - Back-to-back frame period = 10·CLKS_PER_BIT + 1 cycles.
- Requester rules:
  - After seeing gnt, the requester either drops req or presents its next byte on the following cycle.
  - Either is legal because the block is not in IDLE until the frame ends.
- busy rises at edge E and falls at the edge that returns the block to IDLE.
- owner is stable from E until the next grant.
- prio changes take effect only at the next arbitration edge.

## Test plan
Run the bench with CLKS_PER_BIT=4.
1. Reset: hold rst=0 for 3 cycles with req0=1 → txd=1, busy=0, gnt0=gnt1=0 throughout. Release: gnt0 pulses the cycle after the first active edge.
2. Single byte: req0 with data0=0x55 → txd pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. busy is high for 40 cycles. owner=0.
3. Round-robin: prio=0, both reqs held high, data0=0xA5, data1=0x3C → grants alternate 0,1,0,1. Frames start every 41 cycles. Decoded bytes alternate 0xA5 and 0x3C.
4. Fixed priority: prio=1, both reqs held high → only gnt1 pulses for 3 frames. Drop req1 → the next frame goes to port 0.
5. Mid-frame request: req1 asserted during DATA of a port 0 frame → no gnt1 until the edge after STOP ends. Then gnt1 pulses and the frame follows 1 idle cycle later.
6. Reset mid-frame: assert rst=0 at bit 3 of a frame → txd=1 and busy=0 at the next edge. After release, the first tie (prio=0) grants port 0.
